// File: rtl/fb_pixel_writer.sv
`default_nettype none
// ============================================================================
// Module      : fb_pixel_writer
// Description : Frame-buffer write port. Accepts pixel-write and clear-screen
//               commands over valid/ready and emits one linear frame-buffer
//               write per cycle in raster order (address = y*WIDTH + x).
// Revision    : 1.0  initial release
// ============================================================================
module fb_pixel_writer #(
  parameter int WIDTH     = 640,
  parameter int HEIGHT    = 480,
  parameter int COLORBITS = 12
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic                                cmd_clear,
  input  logic [$clog2(WIDTH)-1:0]            cmd_x,
  input  logic [$clog2(HEIGHT)-1:0]           cmd_y,
  input  logic [COLORBITS-1:0]                cmd_color,
  output logic                                fb_we,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]     fb_addr,
  output logic [COLORBITS-1:0]                fb_data,
  output logic                                busy,
  output logic                                dropped
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int AW = $clog2(WIDTH*HEIGHT);

  // Bounds widened by one bit so WIDTH/HEIGHT are representable even when
  // they are exact powers of two.
  localparam logic [XW:0]   C_WIDTH_X  = (XW+1)'(WIDTH);
  localparam logic [YW:0]   C_HEIGHT_Y = (YW+1)'(HEIGHT);
  localparam logic [AW-1:0] C_WIDTH_A  = AW'(WIDTH);
  localparam logic [AW-1:0] C_LAST     = AW'(WIDTH*HEIGHT - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [AW-1:0]          r_count;      // last address issued by the sweep
  logic [COLORBITS-1:0]   r_clear_color;

  logic                   w_accept;
  logic                   w_in_range;
  logic [AW-1:0]          w_pix_addr;

  // Command decode: handshake, range check and raster address of a pixel.
  always_comb begin
    w_accept   = cmd_valid && (r_state == ST_IDLE);
    w_in_range = ({1'b0, cmd_x} < C_WIDTH_X) && ({1'b0, cmd_y} < C_HEIGHT_Y);
    w_pix_addr = AW'(cmd_y) * C_WIDTH_A + AW'(cmd_x);
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and handshake/status outputs.
  always_comb begin
    w_state_next = r_state;
    cmd_ready    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (w_accept && cmd_clear) begin
          w_state_next = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        busy = 1'b1;
        // The last address was already issued; spend this cycle returning
        // to IDLE so busy covers every cycle that carries a sweep write.
        if (r_count == C_LAST) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Registered write port, drop pulse and sweep counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      fb_we         <= 1'b0;
      fb_addr       <= '0;
      fb_data       <= '0;
      dropped       <= 1'b0;
      r_count       <= '0;
      r_clear_color <= '0;
    end else begin
      fb_we   <= 1'b0;
      dropped <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (cmd_clear) begin
              // Address 0 goes out in the cycle right after the accept.
              r_clear_color <= cmd_color;
              r_count       <= '0;
              fb_we         <= 1'b1;
              fb_addr       <= '0;
              fb_data       <= cmd_color;
            end else if (w_in_range) begin
              fb_we   <= 1'b1;
              fb_addr <= w_pix_addr;
              fb_data <= cmd_color;
            end else begin
              dropped <= 1'b1;
            end
          end
        end
        ST_CLEAR: begin
          if (r_count != C_LAST) begin
            fb_we   <= 1'b1;
            fb_addr <= r_count + AW'(1);
            fb_data <= r_clear_color;
            r_count <= r_count + AW'(1);
          end
        end
        default: begin
          fb_we <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fb_pixel_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_pixel_writer
// Description : Directed self-checking bench for fb_pixel_writer, covering a
//               5x3 frame (non power of two) and a 4x4 frame.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fb_pixel_writer;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  // 5x3 instance
  logic       a_valid = 1'b0;
  logic       a_ready;
  logic       a_clear = 1'b0;
  logic [2:0] a_x = '0;
  logic [1:0] a_y = '0;
  logic [3:0] a_color = '0;
  logic       a_we;
  logic [3:0] a_addr;
  logic [3:0] a_data;
  logic       a_busy;
  logic       a_dropped;

  // 4x4 instance
  logic       b_valid = 1'b0;
  logic       b_ready;
  logic       b_clear = 1'b0;
  logic [1:0] b_x = '0;
  logic [1:0] b_y = '0;
  logic [3:0] b_color = '0;
  logic       b_we;
  logic [3:0] b_addr;
  logic [3:0] b_data;
  logic       b_busy;
  logic       b_dropped;

  int tests = 0;
  int fails = 0;

  fb_pixel_writer #(.WIDTH(5), .HEIGHT(3), .COLORBITS(4)) u_a (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (a_valid),
    .cmd_ready (a_ready),
    .cmd_clear (a_clear),
    .cmd_x     (a_x),
    .cmd_y     (a_y),
    .cmd_color (a_color),
    .fb_we     (a_we),
    .fb_addr   (a_addr),
    .fb_data   (a_data),
    .busy      (a_busy),
    .dropped   (a_dropped)
  );

  fb_pixel_writer #(.WIDTH(4), .HEIGHT(4), .COLORBITS(4)) u_b (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (b_valid),
    .cmd_ready (b_ready),
    .cmd_clear (b_clear),
    .cmd_x     (b_x),
    .cmd_y     (b_y),
    .cmd_color (b_color),
    .fb_we     (b_we),
    .fb_addr   (b_addr),
    .fb_data   (b_data),
    .busy      (b_busy),
    .dropped   (b_dropped)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic a_pix(input int x, input int y, input int c);
    a_valid = 1'b1;
    a_clear = 1'b0;
    a_x     = 3'(x);
    a_y     = 2'(y);
    a_color = 4'(c);
  endtask

  initial begin
    // ---------------- reset ----------------
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_we",      32'(a_we),      0);
    chk("rst_addr",    32'(a_addr),    0);
    chk("rst_data",    32'(a_data),    0);
    chk("rst_dropped", 32'(a_dropped), 0);
    chk("rst_ready",   32'(a_ready),   1);
    chk("rst_busy",    32'(a_busy),    0);
    chk("b_rst_ready", 32'(b_ready),   1);
    chk("b_rst_we",    32'(b_we),      0);

    // ---------------- back-to-back pixels ----------------
    a_pix(0, 0, 1);
    tick();
    chk("p0_we",   32'(a_we),   1);
    chk("p0_addr", 32'(a_addr), 0);
    chk("p0_data", 32'(a_data), 1);
    a_pix(4, 2, 7);
    tick();
    chk("p1_we",   32'(a_we),   1);
    chk("p1_addr", 32'(a_addr), 14);
    chk("p1_data", 32'(a_data), 7);
    a_pix(2, 1, 3);
    tick();
    chk("p2_we",   32'(a_we),   1);
    chk("p2_addr", 32'(a_addr), 7);
    chk("p2_data", 32'(a_data), 3);

    // ---------------- out-of-range pixels ----------------
    a_pix(5, 0, 2);
    tick();
    chk("oob_x_we",      32'(a_we),      0);
    chk("oob_x_dropped", 32'(a_dropped), 1);
    chk("oob_x_addr",    32'(a_addr),    7);
    chk("oob_x_data",    32'(a_data),    3);
    a_pix(0, 3, 2);
    tick();
    chk("oob_y_we",      32'(a_we),      0);
    chk("oob_y_dropped", 32'(a_dropped), 1);
    a_pix(1, 1, 5);
    tick();
    chk("after_oob_we",      32'(a_we),      1);
    chk("after_oob_addr",    32'(a_addr),    6);
    chk("after_oob_data",    32'(a_data),    5);
    chk("after_oob_dropped", 32'(a_dropped), 0);
    a_valid = 1'b0;
    tick();
    chk("idle_dropped", 32'(a_dropped), 0);
    chk("idle_we",      32'(a_we),      0);

    // ---------------- clear with valid held ----------------
    a_valid = 1'b1;
    a_clear = 1'b1;
    a_color = 4'd9;
    tick();
    a_pix(3, 0, 10);
    for (int i = 0; i < 15; i++) begin
      chk("clr_we",    32'(a_we),    1);
      chk("clr_addr",  32'(a_addr),  32'(i));
      chk("clr_data",  32'(a_data),  9);
      chk("clr_ready", 32'(a_ready), 0);
      chk("clr_busy",  32'(a_busy),  1);
      tick();
    end
    chk("clr_end_ready", 32'(a_ready), 1);
    chk("clr_end_busy",  32'(a_busy),  0);
    chk("clr_end_we",    32'(a_we),    0);
    tick();
    chk("held_pix_we",   32'(a_we),   1);
    chk("held_pix_addr", 32'(a_addr), 3);
    chk("held_pix_data", 32'(a_data), 10);
    a_valid = 1'b0;
    tick();

    // ---------------- reset during sweep ----------------
    a_valid = 1'b1;
    a_clear = 1'b1;
    a_color = 4'd4;
    tick();
    a_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("mid_addr", 32'(a_addr), 6);
    chk("mid_busy", 32'(a_busy), 1);
    reset = 1'b1;
    tick();
    chk("mid_rst_we",    32'(a_we),    0);
    chk("mid_rst_busy",  32'(a_busy),  0);
    chk("mid_rst_ready", 32'(a_ready), 1);
    reset = 1'b0;
    tick();
    chk("mid_rst_noresume_we",   32'(a_we),   0);
    chk("mid_rst_noresume_busy", 32'(a_busy), 0);
    a_valid = 1'b1;
    a_clear = 1'b1;
    a_color = 4'd2;
    tick();
    a_valid = 1'b0;
    chk("restart_addr", 32'(a_addr), 0);
    chk("restart_data", 32'(a_data), 2);
    chk("restart_busy", 32'(a_busy), 1);
    for (int i = 0; i < 15; i++) tick();
    chk("restart_done_ready", 32'(a_ready), 1);

    // ---------------- reset beats simultaneous accept ----------------
    a_pix(1, 0, 8);
    reset = 1'b1;
    tick();
    chk("rst_acc_we", 32'(a_we), 0);
    reset   = 1'b0;
    a_valid = 1'b0;
    tick();
    chk("rst_acc_we2",   32'(a_we),   0);
    chk("rst_acc_addr",  32'(a_addr), 0);

    // ---------------- 4x4 frame ----------------
    b_valid = 1'b1;
    b_clear = 1'b0;
    b_x     = 2'd3;
    b_y     = 2'd3;
    b_color = 4'd6;
    tick();
    chk("b_pix_we",      32'(b_we),      1);
    chk("b_pix_addr",    32'(b_addr),    15);
    chk("b_pix_data",    32'(b_data),    6);
    chk("b_pix_dropped", 32'(b_dropped), 0);
    b_clear = 1'b1;
    b_color = 4'd1;
    tick();
    b_clear = 1'b0;
    b_x     = 2'd1;
    b_y     = 2'd2;
    for (int i = 0; i < 16; i++) begin
      chk("b_clr_addr",    32'(b_addr),    32'(i));
      chk("b_clr_we",      32'(b_we),      1);
      chk("b_clr_data",    32'(b_data),    1);
      chk("b_clr_dropped", 32'(b_dropped), 0);
      tick();
    end
    chk("b_clr_end_we",    32'(b_we),    0);
    chk("b_clr_end_ready", 32'(b_ready), 1);
    tick();
    chk("b_after_addr", 32'(b_addr), 9);
    chk("b_after_we",   32'(b_we),   1);
    b_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
